banco_registradores_ctx: RTL and testbench
==========================================

Name: banco_registradores_ctx

Overview:
Parametrised multi-bank register file: NBANKS banks of NREGS general registers plus a per-bank HI/LO pair, with two asynchronous read ports and one synchronous write port. The write port takes either a single register or a 2·DATA_W HI/LO word. A built-in context-copy engine moves a whole bank (GPRs plus HI/LO) to another bank, one entry per clock, under a start/busy/done handshake. It sits in the datapath in place of the single-bank file and serves OS/user context switching for the control unit.

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, general registers per bank (power of two, ≥4)
NBANKS, 4, number of banks/contexts (power of two, ≥2)
ZERO_REG, 1, 1 = register 0 of every bank reads as 0 and ignores writes
AW, $clog2(NREGS), register address width (derived)
BW, $clog2(NBANKS), bank select width (derived)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
bank_sel  in  BW  bank used by read ports, rd_data and normal writes
rs_addr  in  AW  read port 1 address
rt_addr  in  AW  read port 2 address
rd_addr  in  AW  write address; also drives rd_data
rs_data  out  DATA_W  bank_sel[rs_addr], combinational
rt_data  out  DATA_W  bank_sel[rt_addr], combinational
rd_data  out  DATA_W  bank_sel[rd_addr], combinational
wr_en  in  1  normal write request
wr_hilo  in  1  1 = write wr_data64 to HI/LO of bank_sel instead of a GPR
wr_data  in  DATA_W  GPR write data
wr_data64  in  2*DATA_W  HI/LO write data; [DATA_W-1:0] to LO, upper half to HI
hi  out  DATA_W  HI of bank_sel, combinational
lo  out  DATA_W  LO of bank_sel, combinational
ctx_start  in  1  one-cycle pulse: start a bank copy
ctx_src  in  BW  source bank, sampled with ctx_start
ctx_dst  in  BW  destination bank, sampled with ctx_start
ctx_busy  out  1  copy in progress
ctx_done  out  1  one-cycle pulse at end of copy
wr_drop  out  1  one-cycle pulse: a normal write was rejected

Behaviour:
- Reset (async, reset_n=0): all GPRs, HI and LO in all banks = 0; FSM→IDLE; ctx_busy=0, ctx_done=0, wr_drop=0. Reset mid-copy aborts the copy; no done pulse.
- Reads are combinational from current storage, with no write bypass. A write at edge N is visible on the read ports after edge N.
- ZERO_REG=1: address 0 reads 0 in every bank. Writes to address 0 have no effect and do not raise wr_drop.
- Normal write at a rising edge when wr_en=1 and ctx_busy=0:
  - wr_hilo=0 → bank_sel[rd_addr] ← wr_data.
  - wr_hilo=1 → LO ← wr_data64[DATA_W-1:0] and HI ← wr_data64[2*DATA_W-1:DATA_W], both in bank_sel, same edge.
- wr_en=1 while ctx_busy=1: write discarded; wr_drop=1 for the next cycle. This applies to any bank.
- FSM states: IDLE, COPY, DONE.
  - IDLE: ctx_start=1 latches ctx_src/ctx_dst and clears index k=0.
    - If src≠dst → COPY.
    - If src=dst → DONE with no data moved.
    - ctx_busy goes 1 on the edge that samples ctx_start.
    - A normal write coincident with ctx_start is still accepted, because busy was 0 at that edge.
  - COPY: each edge copies one entry dst[k] ← src[k]; k increments.
    - k = 0..NREGS-1 are GPRs; k=NREGS is LO; k=NREGS+1 is HI.
    - After k=NREGS+1 → DONE.
    - Copy length is NREGS+2 cycles. With ZERO_REG=1 the k=0 copy still occupies a cycle.
  - DONE: ctx_done=1 for exactly one cycle; ctx_busy=0 in the same cycle; next state IDLE.
  - ctx_start outside IDLE is ignored.
- Latency from the start edge to the ctx_done-high cycle: NREGS+3 edges for src≠dst, 1 edge for src=dst.
- Each copy step reads source storage as it stands at that edge.
- Reads from any bank stay valid during COPY; an entry of dst reflects its new value after its copy edge.
- Address and bank inputs are full-range by construction; there are no out-of-range cases.

Test Plan:
- Reset then read: reset_n=0 for 2 cycles, bank_sel=2, rs_addr=5 → rs_data=0, hi=lo=0, ctx_busy=0.
- GPR/HILO write: bank 1, write 0xDEADBEEF to r7, then wr_hilo with 0x11112222_33334444 → bank1 r7=0xDEADBEEF, hi=0x11112222, lo=0x33334444; bank 0 r7 still 0.
- Zero register: wr_en to r0 with 0xFFFFFFFF → rs_data(r0)=0, wr_drop stays 0.
- Full copy: fill bank 0 with r[i]=i+0x100 and HI=0xA, LO=0xB; start copy 0→3 → ctx_busy high for 34 cycles (NREGS=32), ctx_done pulses once on the 35th edge; bank3 r[i]=i+0x100 (r0=0), hi=0xA, lo=0xB.
- Write during copy: wr_en on r4 of bank 1 at the 5th COPY cycle → write dropped, wr_drop pulses for 1 cycle, bank1 r4 unchanged; ctx_start pulsed again mid-copy is ignored.
- Reset mid-copy and src=dst: reset_n low at COPY k=10 → all regs 0, busy 0, no done pulse. Then start 2→2 → ctx_done pulses one edge later with no data change.

Source files
------------

// File: rtl/banco_registradores_ctx.sv
// Multi-bank register file with per-bank HI/LO and a bank-to-bank context-copy engine.
// State table:  IDLE | waiting for ctx_start;  COPY | moving entry k of src to dst;  DONE | one-cycle completion pulse
module banco_registradores_ctx #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NBANKS   = 4,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS),
    parameter int BW       = $clog2(NBANKS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [BW-1:0]         bank_sel,
    input  logic [AW-1:0]         rs_addr,
    input  logic [AW-1:0]         rt_addr,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic                  wr_hilo,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2*DATA_W-1:0]   wr_data64,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    input  logic                  ctx_start,
    input  logic [BW-1:0]         ctx_src,
    input  logic [BW-1:0]         ctx_dst,
    output logic                  ctx_busy,
    output logic                  ctx_done,
    output logic                  wr_drop
);
    localparam int KW = $clog2(NREGS + 2);

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       src_q, src_d, dst_q, dst_d;
    logic [KW-1:0]       k_q, k_d;
    logic [DATA_W-1:0]   gpr_q [NBANKS][NREGS];
    logic [DATA_W-1:0]   gpr_d [NBANKS][NREGS];
    logic [DATA_W-1:0]   hi_q [NBANKS];
    logic [DATA_W-1:0]   hi_d [NBANKS];
    logic [DATA_W-1:0]   lo_q [NBANKS];
    logic [DATA_W-1:0]   lo_d [NBANKS];
    logic                wr_drop_q, wr_drop_d;
    logic                busy;
    logic                write_zero;

    assign busy       = (state_q == COPY);
    // A GPR write aimed at the hard-wired zero register is a no-op, never a drop.
    assign write_zero = (ZERO_REG != 0) && (rd_addr == '0) && !wr_hilo;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        k_d       = k_q;
        gpr_d     = gpr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        wr_drop_d = wr_en && busy && !write_zero;

        case (state_q)
            IDLE: begin
                if (ctx_start) begin
                    src_d   = ctx_src;
                    dst_d   = ctx_dst;
                    k_d     = '0;
                    state_d = (ctx_src != ctx_dst) ? COPY : DONE;
                end
            end
            COPY: begin
                if (k_q < KW'(NREGS)) begin
                    gpr_d[dst_q][k_q[AW-1:0]] = gpr_q[src_q][k_q[AW-1:0]];
                end else if (k_q == KW'(NREGS)) begin
                    lo_d[dst_q] = lo_q[src_q];
                end else begin
                    hi_d[dst_q] = hi_q[src_q];
                end
                k_d = k_q + 1'b1;
                if (k_q == KW'(NREGS + 1)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Normal writes and copy steps never share an edge: writes need busy low.
        if (wr_en && !busy) begin
            if (wr_hilo) begin
                lo_d[bank_sel] = wr_data64[DATA_W-1:0];
                hi_d[bank_sel] = wr_data64[2*DATA_W-1:DATA_W];
            end else if (!write_zero) begin
                gpr_d[bank_sel][rd_addr] = wr_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            k_q       <= '0;
            wr_drop_q <= 1'b0;
            for (int b = 0; b < NBANKS; b++) begin
                hi_q[b] <= '0;
                lo_q[b] <= '0;
                for (int r = 0; r < NREGS; r++) begin
                    gpr_q[b][r] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            k_q       <= k_d;
            wr_drop_q <= wr_drop_d;
            gpr_q     <= gpr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign rs_data  = ((ZERO_REG != 0) && (rs_addr == '0)) ? '0 : gpr_q[bank_sel][rs_addr];
    assign rt_data  = ((ZERO_REG != 0) && (rt_addr == '0)) ? '0 : gpr_q[bank_sel][rt_addr];
    assign rd_data  = ((ZERO_REG != 0) && (rd_addr == '0)) ? '0 : gpr_q[bank_sel][rd_addr];
    assign hi       = hi_q[bank_sel];
    assign lo       = lo_q[bank_sel];
    assign ctx_busy = busy;
    assign ctx_done = (state_q == DONE);
    assign wr_drop  = wr_drop_q;
endmodule

// File: tb/tb_banco_registradores_ctx.sv
// Self-checking bench for banco_registradores_ctx: vector table, random writes vs array model, copy/reset sequences.
module tb_banco_registradores_ctx;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  bank_sel;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data, rd_data, hi, lo, wr_data;
    logic        wr_en, wr_hilo;
    logic [63:0] wr_data64;
    logic        ctx_start, ctx_busy, ctx_done, wr_drop;
    logic [1:0]  ctx_src, ctx_dst;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_gpr [4][32];
    logic [31:0] m_hi [4];
    logic [31:0] m_lo [4];

    typedef struct {
        logic [1:0]  bank;
        logic [4:0]  addr;
        logic        we;
        logic        hilo;
        logic [31:0] wd;
        logic [63:0] wd64;
        logic [31:0] exp_rs;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_drop;
    } vec_t;
    vec_t vt[8];

    banco_registradores_ctx dut (
        .clock(clock), .reset_n(reset_n), .bank_sel(bank_sel),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data), .rd_data(rd_data),
        .wr_en(wr_en), .wr_hilo(wr_hilo), .wr_data(wr_data), .wr_data64(wr_data64),
        .hi(hi), .lo(lo), .ctx_start(ctx_start), .ctx_src(ctx_src), .ctx_dst(ctx_dst),
        .ctx_busy(ctx_busy), .ctx_done(ctx_done), .wr_drop(wr_drop)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int b, input int a);
        return (a == 0) ? 32'h0 : m_gpr[b][a];
    endfunction

    task automatic m_write(input int b, input int a, input logic hl, input logic [31:0] wd,
                           input logic [63:0] wd64);
        if (hl) begin
            m_lo[b] = wd64[31:0];
            m_hi[b] = wd64[63:32];
        end else if (a != 0) begin
            m_gpr[b][a] = wd;
        end
    endtask

    task automatic m_clear();
        for (int b = 0; b < 4; b++) begin
            m_hi[b] = '0;
            m_lo[b] = '0;
            for (int r = 0; r < 32; r++) m_gpr[b][r] = '0;
        end
    endtask

    task automatic check_bank(input int b);
        bank_sel = 2'(b);
        for (int r = 0; r < 32; r++) begin
            rs_addr = 5'(r);
            #1;
            chk($sformatf("bank%0d_r%0d", b, r), {32'h0, rs_data}, {32'h0, m_read(b, r)});
        end
        chk($sformatf("bank%0d_hi", b), {32'h0, hi}, {32'h0, m_hi[b]});
        chk($sformatf("bank%0d_lo", b), {32'h0, lo}, {32'h0, m_lo[b]});
    endtask

    initial begin
        int bcnt, dcnt, dedge, drop_edge, bad_overlap, rb, ra, rw, rh;
        logic [31:0] rd32;
        logic [63:0] rd64;

        vt[0] = '{2'd1, 5'd7,  1'b1, 1'b0, 32'hDEADBEEF, 64'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0};
        vt[1] = '{2'd1, 5'd7,  1'b1, 1'b1, 32'h0, 64'h11112222_33334444, 32'hDEADBEEF, 32'h11112222, 32'h33334444, 1'b0};
        vt[2] = '{2'd0, 5'd7,  1'b0, 1'b0, 32'h0, 64'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[3] = '{2'd0, 5'd0,  1'b1, 1'b0, 32'hFFFFFFFF, 64'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vt[4] = '{2'd2, 5'd31, 1'b1, 1'b0, 32'h12345678, 64'h0, 32'h12345678, 32'h0, 32'h0, 1'b0};
        vt[5] = '{2'd1, 5'd7,  1'b0, 1'b0, 32'hCAFEF00D, 64'h0, 32'hDEADBEEF, 32'h11112222, 32'h33334444, 1'b0};
        vt[6] = '{2'd3, 5'd5,  1'b1, 1'b1, 32'h99, 64'hAAAA0000_0000BBBB, 32'h0, 32'hAAAA0000, 32'h0000BBBB, 1'b0};
        vt[7] = '{2'd1, 5'd0,  1'b1, 1'b1, 32'h0, 64'h00000001_00000002, 32'h0, 32'h1, 32'h2, 1'b0};

        reset_n = 1'b0; bank_sel = 2'd2; rs_addr = 5'd5; rt_addr = '0; rd_addr = '0;
        wr_en = 0; wr_hilo = 0; wr_data = '0; wr_data64 = '0;
        ctx_start = 0; ctx_src = '0; ctx_dst = '0;
        m_clear();
        cyc(); cyc();
        chk("reset_rs", {32'h0, rs_data}, 64'h0);
        chk("reset_hi", {32'h0, hi}, 64'h0);
        chk("reset_lo", {32'h0, lo}, 64'h0);
        chk("reset_busy", {63'h0, ctx_busy}, 64'h0);
        chk("reset_done", {63'h0, ctx_done}, 64'h0);
        chk("reset_drop", {63'h0, wr_drop}, 64'h0);
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            bank_sel = vt[i].bank; rd_addr = vt[i].addr; rs_addr = vt[i].addr;
            wr_en = vt[i].we; wr_hilo = vt[i].hilo; wr_data = vt[i].wd; wr_data64 = vt[i].wd64;
            cyc();
            wr_en = 0;
            if (vt[i].we) m_write(vt[i].bank, vt[i].addr, vt[i].hilo, vt[i].wd, vt[i].wd64);
            chk($sformatf("vec%0d_rs", i), {32'h0, rs_data}, {32'h0, vt[i].exp_rs});
            chk($sformatf("vec%0d_hi", i), {32'h0, hi}, {32'h0, vt[i].exp_hi});
            chk($sformatf("vec%0d_lo", i), {32'h0, lo}, {32'h0, vt[i].exp_lo});
            chk($sformatf("vec%0d_drop", i), {63'h0, wr_drop}, {63'h0, vt[i].exp_drop});
        end

        for (int i = 0; i < 300; i++) begin
            rb = $urandom_range(0, 3); ra = $urandom_range(0, 31);
            rw = $urandom_range(0, 1); rh = ($urandom_range(0, 5) == 0) ? 1 : 0;
            rd32 = $urandom; rd64 = {$urandom, $urandom};
            bank_sel = 2'(rb); rd_addr = 5'(ra); rs_addr = 5'($urandom_range(0, 31));
            rt_addr = 5'($urandom_range(0, 31));
            wr_en = rw[0]; wr_hilo = rh[0]; wr_data = rd32; wr_data64 = rd64;
            cyc();
            wr_en = 0;
            if (rw != 0) m_write(rb, ra, rh[0], rd32, rd64);
            chk("rand_rs", {32'h0, rs_data}, {32'h0, m_read(rb, int'(rs_addr))});
            chk("rand_rt", {32'h0, rt_data}, {32'h0, m_read(rb, int'(rt_addr))});
            chk("rand_rd", {32'h0, rd_data}, {32'h0, m_read(rb, ra)});
            chk("rand_hi", {32'h0, hi}, {32'h0, m_hi[rb]});
            chk("rand_lo", {32'h0, lo}, {32'h0, m_lo[rb]});
            chk("rand_drop", {63'h0, wr_drop}, 64'h0);
        end

        bank_sel = 2'd0; wr_hilo = 0;
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i); wr_data = 32'(i + 32'h100); wr_en = 1;
            cyc();
            m_write(0, i, 1'b0, 32'(i + 32'h100), 64'h0);
        end
        wr_hilo = 1; wr_data64 = {32'hA, 32'hB};
        cyc();
        m_write(0, 0, 1'b1, 32'h0, {32'hA, 32'hB});
        wr_en = 0; wr_hilo = 0;

        ctx_start = 1; ctx_src = 2'd0; ctx_dst = 2'd3;
        cyc();
        ctx_start = 0;
        bcnt = 0; dcnt = 0; dedge = 0; drop_edge = -1; bad_overlap = 0;
        for (int e = 1; e <= 45; e++) begin
            if (ctx_busy) bcnt++;
            if (ctx_done) begin
                dcnt++; dedge = e;
                if (ctx_busy) bad_overlap = 1;
            end
            chk($sformatf("copy_drop_e%0d", e), {63'h0, wr_drop}, {63'h0, (e == drop_edge)});
            wr_en = 0; ctx_start = 0;
            if (ctx_busy && bcnt == 5) begin
                bank_sel = 2'd1; rd_addr = 5'd4; wr_data = 32'h0BAD0BAD; wr_en = 1;
                ctx_start = 1; ctx_src = 2'd1; ctx_dst = 2'd2;
                drop_edge = e + 1;
            end
            cyc();
        end
        wr_en = 0; ctx_start = 0;
        chk("copy_busy_cycles", 64'(bcnt), 64'd34);
        chk("copy_done_count", 64'(dcnt), 64'd1);
        chk("copy_done_edge", 64'(dedge), 64'd35);
        chk("copy_done_busy_low", 64'(bad_overlap), 64'd0);
        for (int r = 0; r < 32; r++) m_gpr[3][r] = m_gpr[0][r];
        m_hi[3] = m_hi[0]; m_lo[3] = m_lo[0];
        check_bank(3);
        check_bank(1);
        check_bank(2);

        ctx_start = 1; ctx_src = 2'd0; ctx_dst = 2'd3;
        cyc();
        ctx_start = 0;
        repeat (10) cyc();
        chk("midcopy_busy", {63'h0, ctx_busy}, 64'h1);
        reset_n = 0;
        #1;
        chk("abort_busy", {63'h0, ctx_busy}, 64'h0);
        dcnt = 0;
        repeat (2) begin
            cyc();
            if (ctx_done) dcnt++;
        end
        reset_n = 1;
        repeat (4) begin
            cyc();
            if (ctx_done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        m_clear();
        check_bank(0);
        check_bank(3);

        bank_sel = 2'd2; rd_addr = 5'd5; wr_data = 32'h5555; wr_en = 1;
        cyc();
        wr_en = 0;
        m_write(2, 5, 1'b0, 32'h5555, 64'h0);
        ctx_start = 1; ctx_src = 2'd2; ctx_dst = 2'd2;
        cyc();
        ctx_start = 0;
        chk("same_done", {63'h0, ctx_done}, 64'h1);
        chk("same_busy", {63'h0, ctx_busy}, 64'h0);
        cyc();
        chk("same_done_clear", {63'h0, ctx_done}, 64'h0);
        check_bank(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
